// File: rtl/frame_adaptive_target_threshold.sv
// frame_adaptive_target_threshold
//
// Purpose:
//   Consumes the max-surrounding-mean contrast stream and marks target pixels.
//   A pixel is a target when its value is strictly above the active threshold.
//   Each frame, the block records the frame maximum, its (x,y) position and the
//   number of marked pixels. It then derives the threshold for the next frame
//   as max * P_K_NUM >> P_K_SHIFT, saturated to P_DATA_WIDTH bits.
//
// Optional feature (macro THRESH_FLOOR_EN):
//   When defined, the derived threshold is never allowed below P_THRESH_FLOOR.
//   This keeps flat frames from producing a near-zero threshold. When the
//   macro is undefined there is no floor and P_THRESH_FLOOR has no effect.
//
// Ports:
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_v_sync      frame active
//   i_h_sync      pixel valid within line
//   i_data        contrast value
//   o_v_sync      i_v_sync delayed 1 cycle
//   o_h_sync      i_h_sync delayed 1 cycle
//   o_target      pixel above threshold, aligned with o_h_sync
//   o_threshold   threshold currently applied
//   o_frame_done  one-cycle pulse while the frame statistics below update
//   o_frame_max   last frame maximum
//   o_max_x       column of last frame maximum
//   o_max_y       row of last frame maximum
//   o_target_cnt  target pixels in last frame
//
// FSM states:
//   state       | meaning
//   S_WAIT_LOW  | after reset, skip any partial frame until v_sync is low
//   S_IDLE      | vertical blank, waiting for the next frame
//   S_ACTIVE    | frame in progress, accumulating max / target count
//   S_CALC      | one cycle: derive the candidate threshold from the max
//   S_UPDATE    | one cycle: frame_done visible, shadow threshold updated
module frame_adaptive_target_threshold #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_IMG_WIDTH  = 640,
    parameter int P_IMG_HEIGHT = 512,
    parameter int P_K_NUM      = 3,
    parameter int P_K_SHIFT    = 2,
    parameter logic [P_DATA_WIDTH-1:0] P_INIT_THRESHOLD = {P_DATA_WIDTH{1'b1}},
    parameter int P_THRESH_FLOOR = 16
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_v_sync,
    input  logic                                           i_h_sync,
    input  logic [P_DATA_WIDTH-1:0]                        i_data,
    output logic                                           o_v_sync,
    output logic                                           o_h_sync,
    output logic                                           o_target,
    output logic [P_DATA_WIDTH-1:0]                        o_threshold,
    output logic                                           o_frame_done,
    output logic [P_DATA_WIDTH-1:0]                        o_frame_max,
    output logic [$clog2(P_IMG_WIDTH)-1:0]                 o_max_x,
    output logic [$clog2(P_IMG_HEIGHT)-1:0]                o_max_y,
    output logic [$clog2(P_IMG_WIDTH*P_IMG_HEIGHT+1)-1:0]  o_target_cnt
);

    localparam int DW = P_DATA_WIDTH;
    localparam int PW = P_DATA_WIDTH + 8;
    localparam int XW = $clog2(P_IMG_WIDTH);
    localparam int YW = $clog2(P_IMG_HEIGHT);
    localparam int CW = $clog2(P_IMG_WIDTH*P_IMG_HEIGHT+1);
    localparam logic [XW-1:0] X_MAX = XW'(P_IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(P_IMG_HEIGHT - 1);

    if (P_K_NUM < 1 || P_K_NUM > 255 || P_K_SHIFT < 0 || P_K_SHIFT > 15 ||
        P_THRESH_FLOOR < 0) begin : g_bad_param
        $error("frame_adaptive_target_threshold: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_WAIT_LOW,
        S_IDLE,
        S_ACTIVE,
        S_CALC,
        S_UPDATE
    } state_t;

    state_t          state;
    logic            v_d;
    logic            h_d;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [DW-1:0]   run_max;
    logic [XW-1:0]   run_x;
    logic [YW-1:0]   run_y;
    logic            seen;
    logic [CW-1:0]   run_cnt;
    logic [DW-1:0]   thr_active;
    logic [DW-1:0]   thr_shadow;
    logic [DW-1:0]   thr_calc;
    logic            rise_pend;

    logic            valid;
    logic            v_rise;
    logic            v_fall;
    logic            h_fall;
    logic            load_thr;
    logic            acc_clear;
    logic            acc_en;
    logic [DW-1:0]   thr_cmp;
    logic            hit;
    logic [DW-1:0]   base_max;
    logic [XW-1:0]   base_x;
    logic [YW-1:0]   base_y;
    logic            base_seen;
    logic [CW-1:0]   base_cnt;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   prod_shift;
    logic [DW-1:0]   r_sat;
    logic [DW-1:0]   r_final;

    assign valid  = i_v_sync & i_h_sync;
    assign v_rise = i_v_sync & ~v_d;
    assign v_fall = ~i_v_sync & v_d;
    assign h_fall = ~i_h_sync & h_d;

    assign o_v_sync    = v_d;
    assign o_h_sync    = h_d;
    assign o_threshold = thr_active;

    always_comb begin
        load_thr  = (state == S_IDLE) && v_rise;
        // A frame that starts during CALC/UPDATE (short blank) keeps the old
        // threshold. Its accumulators are cleared as UPDATE hands over to ACTIVE.
        acc_clear = load_thr || ((state == S_UPDATE) && (rise_pend || v_rise));
        acc_en    = (state == S_ACTIVE) || acc_clear;
        // The first pixel of a frame may coincide with the threshold load, so
        // it is compared against the value being loaded.
        thr_cmp   = load_thr ? thr_shadow : thr_active;
        hit       = valid && (i_data > thr_cmp);

        base_max  = acc_clear ? '0   : run_max;
        base_x    = acc_clear ? '0   : run_x;
        base_y    = acc_clear ? '0   : run_y;
        base_seen = acc_clear ? 1'b0 : seen;
        base_cnt  = acc_clear ? '0   : run_cnt;

        prod       = PW'(run_max) * PW'(P_K_NUM);
        prod_shift = prod >> P_K_SHIFT;
        r_sat      = (|prod_shift[PW-1:DW]) ? {DW{1'b1}} : prod_shift[DW-1:0];
        r_final    = r_sat;
`ifdef THRESH_FLOOR_EN
        if (r_sat < DW'(P_THRESH_FLOOR)) begin
            r_final = DW'(P_THRESH_FLOOR);
        end
`else
        r_final = r_sat;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_WAIT_LOW;
            v_d          <= 1'b0;
            h_d          <= 1'b0;
            o_target     <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            run_max      <= '0;
            run_x        <= '0;
            run_y        <= '0;
            seen         <= 1'b0;
            run_cnt      <= '0;
            thr_active   <= P_INIT_THRESHOLD;
            thr_shadow   <= P_INIT_THRESHOLD;
            thr_calc     <= '0;
            rise_pend    <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_max  <= '0;
            o_max_x      <= '0;
            o_max_y      <= '0;
            o_target_cnt <= '0;
        end else begin
            v_d      <= i_v_sync;
            h_d      <= i_h_sync;
            o_target <= hit;

            if (!i_v_sync || h_fall) begin
                x_cnt <= '0;
            end else if (valid && (x_cnt != X_MAX)) begin
                x_cnt <= x_cnt + XW'(1);
            end

            if (!i_v_sync) begin
                y_cnt <= '0;
            end else if (h_fall && (y_cnt != Y_MAX)) begin
                y_cnt <= y_cnt + YW'(1);
            end

            if (acc_en) begin
                seen <= base_seen | valid;
                if (valid && (i_data > base_max)) begin
                    run_max <= i_data;
                    run_x   <= x_cnt;
                    run_y   <= y_cnt;
                end else begin
                    run_max <= base_max;
                    run_x   <= base_x;
                    run_y   <= base_y;
                end
                if (hit && !(&base_cnt)) begin
                    run_cnt <= base_cnt + CW'(1);
                end else begin
                    run_cnt <= base_cnt;
                end
            end

            o_frame_done <= 1'b0;

            case (state)
                S_WAIT_LOW: begin
                    if (!i_v_sync) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (v_rise) begin
                        state      <= S_ACTIVE;
                        thr_active <= thr_shadow;
                    end
                end
                S_ACTIVE: begin
                    if (v_fall) begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Statistics and the done pulse are registered here, so they
                    // are visible together for the single UPDATE cycle.
                    thr_calc     <= r_final;
                    rise_pend    <= v_rise;
                    o_frame_done <= 1'b1;
                    if (seen) begin
                        o_frame_max  <= run_max;
                        o_max_x      <= run_x;
                        o_max_y      <= run_y;
                        o_target_cnt <= run_cnt;
                    end else begin
                        o_frame_max  <= '0;
                        o_max_x      <= '0;
                        o_max_y      <= '0;
                        o_target_cnt <= '0;
                    end
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (seen) begin
                        thr_shadow <= thr_calc;
                    end
                    rise_pend <= 1'b0;
                    state     <= (rise_pend || v_rise) ? S_ACTIVE : S_IDLE;
                end
                default: state <= S_WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_adaptive_target_threshold.sv
// tb_frame_adaptive_target_threshold
//
// Purpose: directed bench for frame_adaptive_target_threshold on a 4x2 image.
// The main instance uses K = 3/4. A second instance with K = 5/1 observes
// threshold saturation. Both instances share the same stimulus.
module tb_frame_adaptive_target_threshold;

    localparam int DW = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_v_sync;
    logic            i_h_sync;
    logic [DW-1:0]   i_data;

    logic            o_v_sync, o_h_sync, o_target, o_frame_done;
    logic [DW-1:0]   o_threshold, o_frame_max;
    logic [1:0]      o_max_x;
    logic [0:0]      o_max_y;
    logic [3:0]      o_target_cnt;

    logic            s_v_sync, s_h_sync, s_target, s_frame_done;
    logic [DW-1:0]   s_threshold, s_frame_max;
    logic [1:0]      s_max_x;
    logic [0:0]      s_max_y;
    logic [3:0]      s_target_cnt;

    frame_adaptive_target_threshold #(
        .P_DATA_WIDTH(DW), .P_IMG_WIDTH(4), .P_IMG_HEIGHT(2),
        .P_K_NUM(3), .P_K_SHIFT(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_v_sync(i_v_sync), .i_h_sync(i_h_sync),
        .i_data(i_data), .o_v_sync(o_v_sync), .o_h_sync(o_h_sync),
        .o_target(o_target), .o_threshold(o_threshold),
        .o_frame_done(o_frame_done), .o_frame_max(o_frame_max),
        .o_max_x(o_max_x), .o_max_y(o_max_y), .o_target_cnt(o_target_cnt)
    );

    frame_adaptive_target_threshold #(
        .P_DATA_WIDTH(DW), .P_IMG_WIDTH(4), .P_IMG_HEIGHT(2),
        .P_K_NUM(5), .P_K_SHIFT(0)
    ) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_v_sync(i_v_sync), .i_h_sync(i_h_sync),
        .i_data(i_data), .o_v_sync(s_v_sync), .o_h_sync(s_h_sync),
        .o_target(s_target), .o_threshold(s_threshold),
        .o_frame_done(s_frame_done), .o_frame_max(s_frame_max),
        .o_max_x(s_max_x), .o_max_y(s_max_y), .o_target_cnt(s_target_cnt)
    );

    always #5 i_clk = ~i_clk;

`ifdef THRESH_FLOOR_EN
    localparam logic [31:0] EXP_G_THR  = 32'd16;
    localparam logic [7:0]  EXP_G_MASK = 8'h00;
    localparam logic [3:0]  EXP_G_CNT  = 4'd0;
`else
    localparam logic [31:0] EXP_G_THR  = 32'd0;
    localparam logic [7:0]  EXP_G_MASK = 8'hFE;
    localparam logic [3:0]  EXP_G_CNT  = 4'd7;
`endif

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [DW-1:0] snap_max;
    logic [1:0]    snap_x;
    logic [0:0]    snap_y;
    logic [3:0]    snap_cnt;
    logic [DW-1:0] thr_start, thr_start_sat;
    logic [7:0]    mask;
    logic [DW-1:0] px [8];
    int            c0, d0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Capture the published statistics on every done pulse.
    always @(negedge i_clk) begin
        if (o_frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            snap_max = o_frame_max;
            snap_x   = o_max_x;
            snap_y   = o_max_y;
            snap_cnt = o_target_cnt;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Rise tick with h low, then two lines of 4 pixels, each followed by 2 blank cycles.
    task automatic frame_body(input logic [DW-1:0] p [8]);
        i_v_sync = 1'b1;
        i_h_sync = 1'b0;
        i_data   = '0;
        tick();
        thr_start     = o_threshold;
        thr_start_sat = s_threshold;
        mask          = '0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                i_h_sync = 1'b1;
                i_data   = p[y*4+x];
                tick();
                mask[y*4+x] = o_target;
            end
            i_h_sync = 1'b0;
            i_data   = '0;
            tick();
            tick();
        end
    endtask

    task automatic frame_end(input string tag);
        int c_start, d_start;
        i_v_sync = 1'b0;
        c_start  = cyc;
        d_start  = done_cnt;
        repeat (5) tick();
        chk({tag, "_done_cnt"}, 64'(done_cnt - d_start), 64'd1);
        chk({tag, "_done_lat"}, 64'(done_cyc - c_start), 64'd2);
    endtask

    task automatic stats(input string tag, input logic [DW-1:0] mx, input logic [1:0] x,
                         input logic [0:0] y, input logic [3:0] cnt);
        chk({tag, "_max"}, 64'(snap_max), 64'(mx));
        chk({tag, "_x"},   64'(snap_x),   64'(x));
        chk({tag, "_y"},   64'(snap_y),   64'(y));
        chk({tag, "_cnt"}, 64'(snap_cnt), 64'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_v_sync = 1'b0; i_h_sync = 1'b0; i_data = '0;
        repeat (3) tick();
        chk("rst_thr",  64'(o_threshold), 64'hFFFF_FFFF);
        chk("rst_done", 64'(o_frame_done), 64'd0);
        chk("rst_max",  64'(o_frame_max), 64'd0);
        chk("rst_cnt",  64'(o_target_cnt), 64'd0);
        i_rst = 1'b0;
        tick();

        // A: ramp 0..7 with the reset threshold; nothing marked.
        px = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        frame_body(px);
        chk("a_thr",  64'(thr_start), 64'hFFFF_FFFF);
        chk("a_mask", 64'(mask), 64'h00);
        frame_end("a");
        stats("a", 32'd7, 2'd3, 1'd1, 4'd0);

        // B: same ramp, threshold 7*3>>2 = 5, so only 6 and 7 are marked.
        frame_body(px);
        chk("b_thr",  64'(thr_start), 64'd5);
        chk("b_mask", 64'(mask), 64'hC0);
        frame_end("b");
        stats("b", 32'd7, 2'd3, 1'd1, 4'd2);

        // Mid-frame reset: the partial frame must never complete.
        i_v_sync = 1'b1; i_h_sync = 1'b0; tick();
        i_h_sync = 1'b1; i_data = 32'd100; tick();
        i_data = 32'd101; tick();
        d0 = done_cnt;
        i_rst = 1'b1;
        tick();
        chk("mrst_vs",  64'(o_v_sync), 64'd0);
        chk("mrst_hs",  64'(o_h_sync), 64'd0);
        chk("mrst_tgt", 64'(o_target), 64'd0);
        chk("mrst_thr", 64'(o_threshold), 64'hFFFF_FFFF);
        tick(); tick();
        chk("mrst_max", 64'(o_frame_max), 64'd0);
        chk("mrst_x",   64'(o_max_x), 64'd0);
        chk("mrst_y",   64'(o_max_y), 64'd0);
        chk("mrst_cnt", 64'(o_target_cnt), 64'd0);
        i_rst = 1'b0;
        i_data = 32'd200; tick(); tick();
        i_h_sync = 1'b0; tick();
        i_v_sync = 1'b0;
        repeat (6) tick();
        chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);

        // C: tie of 9 at (1,0) and (2,1) keeps the first; next threshold 27>>2 = 6.
        px = '{32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd0};
        frame_body(px);
        chk("c_thr",  64'(thr_start), 64'hFFFF_FFFF);
        chk("c_mask", 64'(mask), 64'h00);
        frame_end("c");
        stats("c", 32'd9, 2'd1, 1'd0, 4'd0);

        // Empty frame: stats publish as zero, threshold unchanged.
        i_v_sync = 1'b1; i_h_sync = 1'b0; tick();
        chk("empty_thr", 64'(o_threshold), 64'd6);
        repeat (6) tick();
        frame_end("empty");
        stats("empty", 32'd0, 2'd0, 1'd0, 4'd0);

        // D: max all-ones, followed by a 1-cycle vertical blank into E.
        px = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        frame_body(px);
        chk("d_thr",  64'(thr_start), 64'd6);
        chk("d_mask", 64'(mask), 64'h01);
        i_v_sync = 1'b0;
        c0 = cyc;
        d0 = done_cnt;
        tick();
        // E starts during D's CALC, so it must still run with threshold 6.
        px = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
        frame_body(px);
        chk("d_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("d_done_lat", 64'(done_cyc - c0), 64'd2);
        stats("d", 32'hFFFF_FFFF, 2'd0, 1'd0, 4'd1);
        chk("e_thr",  64'(thr_start), 64'd6);
        chk("e_mask", 64'(mask), 64'h20);
        frame_end("e");
        stats("e", 32'hFFFF_FFFF, 2'd1, 1'd1, 4'd1);

        // F: 3*FFFF_FFFF>>2 = BFFF_FFFF; the K=5/1 instance saturates.
        px = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        frame_body(px);
        chk("f_thr",     64'(thr_start), 64'hBFFF_FFFF);
        chk("f_thr_sat", 64'(thr_start_sat), 64'hFFFF_FFFF);
        chk("f_mask",    64'(mask), 64'h00);
        frame_end("f");
        stats("f", 32'd1, 2'd0, 1'd0, 4'd0);

        // G: flat frame of 1 gives 3>>2 = 0, or the floor of 16 when enabled.
        px = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        frame_body(px);
        chk("g_thr",  64'(thr_start), 64'(EXP_G_THR));
        chk("g_mask", 64'(mask), 64'(EXP_G_MASK));
        frame_end("g");
        stats("g", 32'd7, 2'd3, 1'd1, EXP_G_CNT);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_adaptive_target_threshold.md
Name: frame_adaptive_target_threshold

Overview:
- Downstream consumer of the max-surrounding-mean contrast stream.
- Per frame: tracks the frame maximum and its (x,y) position, then derives the next frame's threshold as max*P_K_NUM>>P_K_SHIFT.
- Marks each valid pixel whose value exceeds the active threshold and counts marked pixels per frame.
- Feeds the target-marking/overlay stage.

Parameters:
- P_DATA_WIDTH, 32, width of input contrast value and threshold
- P_IMG_WIDTH, 640, valid pixels per line (sizes x counter)
- P_IMG_HEIGHT, 512, valid lines per frame (sizes y counter)
- P_K_NUM, 3, threshold multiplier numerator (1..255)
- P_K_SHIFT, 2, threshold right shift (0..15)
- P_INIT_THRESHOLD, 32'hFFFF_FFFF, active threshold after reset
- P_THRESH_FLOOR, 16, minimum threshold (used only with THRESH_FLOOR_EN)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_v_sync  input  1  frame active
- i_h_sync  input  1  pixel valid within line
- i_data  input  P_DATA_WIDTH  contrast value
- o_v_sync  output  1  i_v_sync delayed 1 cycle
- o_h_sync  output  1  i_h_sync delayed 1 cycle
- o_target  output  1  pixel exceeds threshold, aligned with o_h_sync
- o_threshold  output  P_DATA_WIDTH  threshold currently applied
- o_frame_done  output  1  one-cycle pulse when the stats below update
- o_frame_max  output  P_DATA_WIDTH  last frame maximum
- o_max_x  output  $clog2(P_IMG_WIDTH)  column of last frame maximum
- o_max_y  output  $clog2(P_IMG_HEIGHT)  row of last frame maximum
- o_target_cnt  output  $clog2(P_IMG_WIDTH*P_IMG_HEIGHT+1)  target pixels in last frame

Behaviour:
- Clocking/reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: all outputs 0 except o_threshold = P_INIT_THRESHOLD. Internal counters, running max, and shadow threshold (= P_INIT_THRESHOLD) reset; FSM enters WAIT_LOW.
- Pixel valid = i_v_sync & i_h_sync. Edges are detected against a 1-cycle registered copy of each sync.
- Pixel path, latency 1:
  - o_v_sync and o_h_sync are registered copies of the inputs.
  - o_target <= valid & (i_data > active threshold); strict greater-than. o_target is 0 whenever valid is 0.
- x counter: increments on each valid pixel; clears on i_h_sync falling edge and while i_v_sync = 0.
- y counter: increments on i_h_sync falling edge while i_v_sync = 1; clears while i_v_sync = 0.
- Both counters saturate at their maximum.
- Running max: on a valid pixel, if i_data > running max (strict), capture value, x and y. Ties keep the first occurrence. A seen flag sets on the first valid pixel of the frame.
- Target counter: +1 per asserted o_target; saturates at all-ones.
- FSM:
  - WAIT_LOW: go to IDLE once i_v_sync = 0 is sampled. This skips any partial frame present at reset release.
  - IDLE: on i_v_sync rising edge, go to ACTIVE; load active threshold from shadow; clear running max, seen flag and target counter.
  - ACTIVE: on i_v_sync falling edge, go to CALC.
  - CALC (1 cycle): prod = running_max * P_K_NUM, computed at full width P_DATA_WIDTH+8. Result r = prod >> P_K_SHIFT; if r exceeds all-ones of P_DATA_WIDTH, r = all-ones.
  - UPDATE (1 cycle): pulse o_frame_done and publish o_frame_max, o_max_x, o_max_y, o_target_cnt. If seen = 1, shadow <= r; if seen = 0, shadow is unchanged and stats publish as 0. Then go to IDLE.
- o_threshold shows the active threshold. A new threshold takes effect only at the next i_v_sync rising edge.
- Short vertical blank: if i_v_sync rises while in CALC or UPDATE, that frame uses the old shadow. The FSM completes UPDATE, then enters ACTIVE directly, clearing the frame accumulators at that point. The new threshold applies from the following frame.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded and produces no o_frame_done.

Optional Feature:
- Macro THRESH_FLOOR_EN.
- Defined: in CALC, r = max(r, P_THRESH_FLOOR) after saturation. This prevents near-zero thresholds on flat frames.
- Undefined: no floor; P_THRESH_FLOOR is unused.

Test Plan:
- Reset check: assert i_rst for 3 cycles mid-frame -> all outputs 0, o_threshold = FFFF_FFFF, no o_frame_done until a complete new frame has passed.
- Bench config W=4, H=2, K=3/4. Frame 1 data 0..7 raster -> o_target never set. o_frame_done pulses 2 cycles after v_sync falls with o_frame_max=7, o_max_x=3, o_max_y=1, o_target_cnt=0. Next o_threshold = 5.
- Repeat same frame -> o_target set on values 6 and 7 only. o_target_cnt = 2, threshold stays 5.
- Tie: values 9 at (1,0) and (2,1), all others 0 -> o_max_x=1, o_max_y=0. Empty frame (v_sync high, h_sync never) -> o_frame_done pulses, stats 0, threshold unchanged.
- Saturation: K_NUM=5, K_SHIFT=0, pixel FFFF_FFFF -> next threshold FFFF_FFFF. Short blank: v_sync low 1 cycle -> next frame still uses old threshold; new threshold appears one frame later.
- THRESH_FLOOR_EN defined, all-ones-valued frame of 1 -> threshold 16. Undefined -> threshold 0.
